// File: rtl/led_arbiter_pkg.sv
// led_arbiter_pkg
//   Shared types and helpers for the status-LED arbiter.
//   - state_t : arbiter FSM states
//   - pick_t  : result of a round-robin search (valid flag + index)
//   - gray4   : 4-bit binary to Gray conversion for the idle heartbeat
//   - rr_pick : first set request at or after 'start', wrapping at 'last'
package led_arbiter_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic logic [3:0] gray4(input logic [3:0] hb);
        return hb ^ (hb >> 1);
    endfunction

    // 'last' is the highest valid requester index (N_REQ-1). The search
    // visits at most last+1 positions, starting at 'start' and wrapping to 0.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   start,
                                      input logic [IDX_W-1:0]   last);
        pick_t            r;
        logic [IDX_W-1:0] idx;
        r   = '0;
        idx = start;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k <= 32'(last) && !r.valid && req[idx]) begin
                r.valid = 1'b1;
                r.idx   = idx;
            end
            idx = (idx == last) ? '0 : idx + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_arbiter_tick_prescaler.sv
// tick_prescaler
//   Free-running prescaler producing a one-cycle tick every 2^LOG2DELAY
//   clock cycles (when the counter is all ones).
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset (counter cleared)
//     tick - one-cycle pulse
module tick_prescaler #(
    parameter int unsigned LOG2DELAY = 21
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [LOG2DELAY-1:0] pre_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + LOG2DELAY'(1);
        end
    end

    assign tick = &pre_q;

endmodule

// File: rtl/led_arbiter.sv
// led_arbiter
//   Shares the four board LEDs between N_REQ requesters with round-robin
//   ownership and a minimum hold time in prescaler ticks. Shows a Gray-coded
//   heartbeat when nobody requests. All outputs are registered.
//   Ports:
//     clk        - system clock (after global buffer)
//     rst        - asynchronous active-high reset
//     req        - level request per requester
//     pat        - 4-bit pattern per requester, pat[4i+3] drives led0
//     grant      - one-hot current owner, zero when idle
//     led0..led3 - registered LED drives
module led_arbiter
    import led_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned LOG2DELAY  = 21,
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [4*N_REQ-1:0] pat,
    output logic [N_REQ-1:0]   grant,
    output logic               led0,
    output logic               led1,
    output logic               led2,
    output logic               led3
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       HOLD = 8'(HOLD_TICKS);

    logic             tick;
    state_t           state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_q;
    logic [7:0]       hold_q;
    logic [3:0]       hb_q;
    logic [N_REQ-1:0] grant_q;
    logic [3:0]       led_q;

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] others;
    logic [IDX_W-1:0]   after_owner;
    logic               owner_req;
    logic [7:0]         hold_inc_d;
    logic [3:0]         pat_sel;
    logic [3:0]         led_d;
    pick_t              pick_idle;
    pick_t              pick_next;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + 3'd1;
    endfunction

    tick_prescaler #(
        .LOG2DELAY(LOG2DELAY)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = req;
        others             = req_ext;
        others[owner_q]    = 1'b0;
        owner_req          = req_ext[owner_q];
        after_owner        = wrap_inc(owner_q);
        hold_inc_d         = (hold_q == HOLD) ? hold_q : hold_q + 8'd1;
        pick_idle          = rr_pick(req_ext, rr_q, LAST);
        // The owner is masked out, so this serves both the drop and the
        // rotation case; on a drop rr_q already equals after_owner.
        pick_next          = rr_pick(others, after_owner, LAST);
        pat_sel            = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                pat_sel = pat[4*i +: 4];
            end
        end
        led_d = (state_q == OWN) ? pat_sel : gray4(hb_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q <= '0;
        end else if (tick) begin
            hb_q <= hb_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            led_q   <= '0;
        end else begin
            led_q <= led_d;
            case (state_q)
                IDLE: begin
                    hold_q <= '0;
                    if (pick_idle.valid) begin
                        state_q <= OWN;
                        owner_q <= pick_idle.idx;
                        grant_q <= onehot(pick_idle.idx);
                        rr_q    <= wrap_inc(pick_idle.idx);
                    end
                end
                OWN: begin
                    // A drop takes priority over a simultaneous rotation.
                    if (!owner_req) begin
                        hold_q <= '0;
                        if (pick_next.valid) begin
                            owner_q <= pick_next.idx;
                            grant_q <= onehot(pick_next.idx);
                            rr_q    <= wrap_inc(pick_next.idx);
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (tick) begin
                        if (hold_inc_d == HOLD && pick_next.valid) begin
                            owner_q <= pick_next.idx;
                            grant_q <= onehot(pick_next.idx);
                            rr_q    <= wrap_inc(pick_next.idx);
                            hold_q  <= '0;
                        end else begin
                            hold_q <= hold_inc_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign {led0, led1, led2, led3} = led_q;

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Status-LED arbiter for the xc7 board designs. It shares the four board LEDs between up to N_REQ requesters, for example a heartbeat, error flags or debug patterns. Ownership rotates round-robin, with a minimum hold time measured in prescaler ticks. When no requester is active, it drives the built-in Gray-coded heartbeat. It sits after the global clock buffer and drives the LED pins directly.

## Interface
- N_REQ, 4: number of requesters (2..8).
- LOG2DELAY, 21: prescaler width; one tick every 2^LOG2DELAY clk cycles.
- HOLD_TICKS, 8: minimum ticks an owner keeps the LEDs while others wait (1..255).
- clk  input  1  system clock, single domain (output of the global clock buffer).
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  level request per requester.
- pat  input  4*N_REQ  pattern per requester; requester i uses pat[4i+3:4i], with bit 3 driving led0.
- grant  output  N_REQ  one-hot current owner; all zero in IDLE.
- led0..led3  output  1 each  registered LED drives.

## Operation
- Prescaler: counter pre[LOG2DELAY-1:0] increments every cycle and wraps.
  - Internal tick pulses for one cycle when pre is all ones.
- Heartbeat: 4-bit hb increments on tick and wraps 15→0.
  - IDLE display is {led0..led3} = hb ^ (hb >> 1).
- State IDLE:
  - If any req is high, go to OWN on the next edge.
  - owner = first i with req[i] high, searching from rr_ptr upward modulo N_REQ.
  - hold_cnt is cleared to 0.
- State OWN, tick handling:
  - On tick, hold_cnt increments and saturates at HOLD_TICKS.
- State OWN, owner drops:
  - If req[owner] is low, the owner releases on the next edge, regardless of hold_cnt or tick.
  - If another req is high, the next owner is picked round-robin after the old owner, and hold_cnt is cleared.
  - Otherwise the state goes to IDLE.
- State OWN, rotation:
  - Condition: tick is high, hold_cnt (post-increment value) equals HOLD_TICKS, and any other req is high.
  - Result: switch to the next requester round-robin after the owner, and clear hold_cnt.
- State OWN, lone requester: a single continuous requester keeps ownership indefinitely.
- rr_ptr: on every grant, rr_ptr = (new owner + 1) mod N_REQ.
- Simultaneous events:
  - Owner drop together with a rotation condition: the drop rule applies.
  - A request arriving in the same cycle as a tick in IDLE is granted normally; hb still increments.
- LED mux: next value = pat[owner] in OWN, gray(hb) in IDLE. The mux is registered.
- Reset mid-operation (async rst):
  - State returns to IDLE, and grant goes to 0 immediately.
  - pre, hb, hold_cnt and rr_ptr go to 0.
  - led0..led3 go to 0.
  - Operation resumes on the first edge after rst deasserts.

## Timing
- req rising in IDLE at edge k: grant valid after edge k+1; LEDs show pat after edge k+2.
- Owner drop: grant changes at the edge after req falls; LEDs follow one cycle later.
- pat changes by the owner: visible on LEDs one cycle later.
- Rotation: occurs on the tick edge; LED update follows one cycle later.
- Reset values: grant=0, led0..led3=0, state=IDLE, pre=0, hb=0, rr_ptr=0.
- No combinational path from req or pat to any output.

## Structure
- Package led_arbiter_pkg contains:
  - state enum {IDLE, OWN};
  - function gray4(hb);
  - function rr_pick(req, start), returning an index and a valid flag.
- Sub-module tick_prescaler:
  - parameter LOG2DELAY; ports clk, rst, tick.
  - Reused by other board demos.
- Top level contains the FSM, hold counter, round-robin pointer and output register.

## Test plan
Bench parameters: N_REQ=4, LOG2DELAY=3 (tick every 8 cycles), HOLD_TICKS=2.
- Idle heartbeat: no req for 40 cycles after reset.
  - Expected: grant=0; LEDs step 0000→0001→0011→0010→0110, one step per tick.
- Single request: req=0010, pat1=1010.
  - Expected: grant=0010 after 1 cycle; LEDs=1010 after 2 cycles; ownership held indefinitely.
- Rotation: req=0110 held.
  - Expected: owner 1 for exactly 2 ticks, then grant=0100 on a tick edge, then back to 0010 after 2 more ticks.
- Early drop: owner 2 drops req at hold_cnt=0 while req0 is high.
  - Expected: grant=0001 the next cycle; no wait for a tick.
- Wrap and fairness: req=1001 held with rr_ptr=3.
  - Expected: owner sequence 3→0→3.
- Async reset: assert rst mid-OWN between clock edges.
  - Expected: grant=0 and LEDs=0000 before the next edge.
  - After release with req=0000: heartbeat restarts from 0000.
